wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Write-back port arbiter sharing the register file's single write port between the ALU result path and the load (memory) result path. Accepts one write per cycle via valid/ready handshakes, registers the selected write onto the register-file write port, discards writes to x0 without consuming the port, and prevents ALU starvation under sustained load traffic with a bounded-wait counter. Sits between the execute/memory stages and the register file.

## Interface

- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register address width (32 registers)
- STARVE_LIMIT, 4, consecutive lost cycles before the ALU is forced to win; legal range 1..15
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- alu_valid  input  1  ALU write request
- alu_rd  input  ADDR_WIDTH  ALU destination register
- alu_data  input  DATA_WIDTH  ALU result
- alu_ready  output  1  ALU request accepted this cycle (combinational)
- mem_valid  input  1  load write request
- mem_rd  input  ADDR_WIDTH  load destination register
- mem_data  input  DATA_WIDTH  load result
- mem_ready  output  1  load request accepted this cycle (combinational)
- rf_wr_en  output  1  register-file write enable (registered)
- rf_wr_addr  output  ADDR_WIDTH  register-file write address (registered)
- rf_wr_data  output  DATA_WIDTH  register-file write data (registered)
- alu_starved  output  1  high while the starvation counter equals STARVE_LIMIT (registered)

## Operation

- Handshake: transfer occurs when valid && ready in the same cycle. A requester holds valid, rd and data stable until accepted; ready never depends on the requester's own data.
- x0 writes: a request with rd == 0 is accepted immediately (ready = 1 whenever valid and not rst), independent of the other requester; no register-file write results.
- Non-zero requests compete for the port; exactly one is accepted per cycle:
  - only one valid: it wins.
  - both valid, starve_cnt < STARVE_LIMIT: mem wins (loads are older).
  - both valid, starve_cnt == STARVE_LIMIT: ALU wins.
  - both valid, alu_rd == mem_rd: mem always wins regardless of starve_cnt (older write first; the ALU write follows and is final).
- Starvation counter starve_cnt (4 bits):
  - cleared on any ALU acceptance or when alu_valid is low.
  - incremented when the ALU presents a non-zero request and is not accepted, saturating at STARVE_LIMIT.
- Output register: on a non-zero acceptance, next cycle rf_wr_en = 1 with the winner's rd/data; with no non-zero acceptance, next cycle rf_wr_en = 0 and rf_wr_addr/rf_wr_data hold their previous values.
- rf_wr_en is never asserted with rf_wr_addr == 0.

## Timing

- Reset (rst high at a rising edge): rf_wr_en = 0, rf_wr_addr = 0, rf_wr_data = 0, starve_cnt = 0, alu_starved = 0. While rst is high, alu_ready = mem_ready = 0 combinationally, so nothing is accepted.
- Reset mid-operation: a write registered in the cycle before rst is presented on rf_wr_* only until the reset edge; any request pending during reset is re-arbitrated from starve_cnt = 0 afterwards.
- Latency: acceptance in cycle N -> rf_wr_en in cycle N+1. Throughput: one register write per cycle.
- alu_starved reflects starve_cnt as of the previous edge; a forced ALU grant clears it the cycle after acceptance.
- Worst-case ALU wait with continuous distinct-rd loads: STARVE_LIMIT lost cycles, then granted.

## Test plan

- Reset: drive both valids with non-zero rd during rst -> both readies 0; after release, rf_wr_en = 0, rf_wr_addr = 0, rf_wr_data = 0, alu_starved = 0.
- Single requester: alu_valid, rd=5, data=0xDEADBEEF for one cycle -> alu_ready = 1 same cycle; next cycle rf_wr_en = 1, rf_wr_addr = 5, rf_wr_data = 0xDEADBEEF; then rf_wr_en = 0.
- Contention and starvation (STARVE_LIMIT = 4): ALU rd=3 held, mem issues rd=7,8,9,10,11 back-to-back -> mem wins 4 cycles, alu_starved = 1, ALU rd=3 accepted in the 5th cycle, then mem rd=11 next.
- Same-rd collision at starve_cnt = STARVE_LIMIT: both rd=12, mem=0x1, alu=0x2 -> writes 12<-0x1 then 12<-0x2 on consecutive cycles.
- x0 handling: ALU rd=0 and mem rd=4 same cycle -> both ready = 1; only one write (addr 4); both rd=0 -> both accepted, rf_wr_en stays 0.
- Mid-stream reset: assert rst for one cycle during back-to-back mem writes with starve_cnt = 3 -> rf_wr_en = 0 and starve_cnt = 0 after the edge; arbitration resumes with mem priority.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares the register-file write port between the ALU
// and load result paths, with loads preferred and a bounded ALU wait.
module wb_port_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    output logic                  rf_wr_en,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  alu_starved
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic                  alu_nz;
    logic                  mem_nz;
    logic                  alu_win;
    logic                  mem_win;

    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic                  starved_q, starved_d;
    logic                  wr_en_q,   wr_en_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;

    // Arbitration: x0 writes are always absorbed; non-zero writes contend.
    always_comb begin
        alu_nz  = alu_valid && (alu_rd != '0);
        mem_nz  = mem_valid && (mem_rd != '0);
        alu_win = 1'b0;
        mem_win = 1'b0;
        if (!rst) begin
            if (alu_nz && mem_nz) begin
                // Same destination: the older load must land first so the ALU write is final.
                if ((alu_rd == mem_rd) || (cnt_q != LIMIT)) begin
                    mem_win = 1'b1;
                end else begin
                    alu_win = 1'b1;
                end
            end else begin
                alu_win = alu_nz;
                mem_win = mem_nz;
            end
        end
        alu_ready = !rst && alu_valid && ((alu_rd == '0) || alu_win);
        mem_ready = !rst && mem_valid && ((mem_rd == '0) || mem_win);
    end

    // Next-state for the starvation counter and the write-port register.
    always_comb begin
        cnt_d   = cnt_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        if (!alu_valid || alu_ready) begin
            cnt_d = '0;
        end else if (alu_nz && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (alu_win) begin
            wr_en_d = 1'b1;
            addr_d  = alu_rd;
            data_d  = alu_data;
        end else if (mem_win) begin
            wr_en_d = 1'b1;
            addr_d  = mem_rd;
            data_d  = mem_data;
        end
        starved_d = (cnt_d == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            starved_q <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            starved_q <= starved_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign rf_wr_en    = wr_en_q;
    assign rf_wr_addr  = addr_q;
    assign rf_wr_data  = data_q;
    assign alu_starved = starved_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, single writes, contention,
// starvation, same-rd collision, x0 handling and mid-stream reset.
module tb_wb_port_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid;
    logic [AW-1:0] alu_rd, mem_rd;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic          rf_wr_en;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic          alu_starved;

    int n_checks = 0;
    int n_errors = 0;

    wb_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .alu_starved(alu_starved)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        #1;
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        check({tag, "_en"},   32'(rf_wr_en),   32'(en));
        check({tag, "_addr"}, 32'(rf_wr_addr), 32'(a));
        check({tag, "_data"}, rf_wr_data,      d);
    endtask

    task automatic check_rdy(input string tag, input logic ar, input logic mr);
        check({tag, "_alu_ready"}, 32'(alu_ready), 32'(ar));
        check({tag, "_mem_ready"}, 32'(mem_ready), 32'(mr));
    endtask

    initial begin
        // Reset with both requesters active.
        rst = 1'b1;
        drive(1'b1, 5'd5, 32'h1111, 1'b1, 5'd6, 32'h2222);
        tick();
        check_rdy("rst_hold", 1'b0, 1'b0);
        tick();
        check_wr("rst", 1'b0, 5'd0, 32'h0);
        check("rst_starved", 32'(alu_starved), 32'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst = 1'b0;
        tick();
        check_wr("idle", 1'b0, 5'd0, 32'h0);

        // Single ALU write.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        check_rdy("single", 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_wr("single_wr", 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check_wr("single_after", 1'b0, 5'd5, 32'hDEADBEEF);

        // Starvation: ALU rd=3 held against loads rd=7..10, then forced grant.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 32'h33, 1'b1, AW'(7 + i), DW'(32'h70 + i));
            check_rdy($sformatf("starve%0d", i), 1'b0, 1'b1);
            tick();
            check_wr($sformatf("starve%0d_wr", i), 1'b1, AW'(7 + i), DW'(32'h70 + i));
            check($sformatf("starve%0d_flag", i), 32'(alu_starved), 32'(i == 3));
        end
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd11, 32'h7B);
        check_rdy("forced", 1'b1, 1'b0);
        tick();
        check_wr("forced_wr", 1'b1, 5'd3, 32'h33);
        check("forced_flag", 32'(alu_starved), 32'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'h7B);
        check_rdy("mem11", 1'b0, 1'b1);
        tick();
        check_wr("mem11_wr", 1'b1, 5'd11, 32'h7B);

        // Same-rd collision once the counter is saturated.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd12, 32'h2, 1'b1, AW'(20 + i), DW'(i));
            tick();
        end
        check("coll_pre_flag", 32'(alu_starved), 32'd1);
        drive(1'b1, 5'd12, 32'h2, 1'b1, 5'd12, 32'h1);
        check_rdy("coll", 1'b0, 1'b1);
        tick();
        check_wr("coll_mem_wr", 1'b1, 5'd12, 32'h1);
        drive(1'b1, 5'd12, 32'h2, 1'b0, 5'd0, 32'h0);
        check_rdy("coll_alu", 1'b1, 1'b0);
        tick();
        check_wr("coll_alu_wr", 1'b1, 5'd12, 32'h2);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();

        // x0 handling.
        drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd4, 32'h44);
        check_rdy("x0_alu", 1'b1, 1'b1);
        tick();
        check_wr("x0_alu_wr", 1'b1, 5'd4, 32'h44);
        drive(1'b1, 5'd0, 32'h66, 1'b1, 5'd0, 32'h77);
        check_rdy("x0_both", 1'b1, 1'b1);
        tick();
        check_wr("x0_both_wr", 1'b0, 5'd4, 32'h44);
        drive(1'b1, 5'd6, 32'h60, 1'b1, 5'd0, 32'h77);
        check_rdy("x0_mem", 1'b1, 1'b1);
        tick();
        check_wr("x0_mem_wr", 1'b1, 5'd6, 32'h60);

        // Mid-stream reset with starve_cnt = 3.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd9, 32'h99, 1'b1, AW'(13 + i), DW'(32'hA0 + i));
            tick();
        end
        check_wr("pre_rst_wr", 1'b1, 5'd15, 32'hA2);
        check("pre_rst_flag", 32'(alu_starved), 32'd0);
        rst = 1'b1;
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd16, 32'hB0);
        check_rdy("mid_rst", 1'b0, 1'b0);
        tick();
        check_wr("mid_rst_wr", 1'b0, 5'd0, 32'h0);
        check("mid_rst_flag", 32'(alu_starved), 32'd0);
        rst = 1'b0;
        // Counter restarted from 0: mem must win four more times.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd9, 32'h99, 1'b1, AW'(16 + i), DW'(32'hB0 + i));
            check_rdy($sformatf("post_rst%0d", i), 1'b0, 1'b1);
            tick();
            check_wr($sformatf("post_rst%0d_wr", i), 1'b1, AW'(16 + i), DW'(32'hB0 + i));
            check($sformatf("post_rst%0d_flag", i), 32'(alu_starved), 32'(i == 3));
        end
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd20, 32'hB4);
        check_rdy("post_rst_forced", 1'b1, 1'b0);
        tick();
        check_wr("post_rst_forced_wr", 1'b1, 5'd9, 32'h99);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        check_wr("final_idle", 1'b0, 5'd9, 32'h99);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
